segmented_cla_adder: RTL

SEGMENTED_CLA_ADDER -- requirements
Module: segmented_cla_adder

---
 rtl/segmented_cla_adder.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/segmented_cla_adder.sv
// Multi-cycle adder/subtractor: one CHUNK-wide carry-lookahead group per clock,
// with a valid/ready handshake on both sides.
module segmented_cla_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  input  logic             flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int unsigned CHUNK_SAFE = (CHUNK == 0) ? 1 : CHUNK;
  localparam int unsigned NCH        = WIDTH / CHUNK_SAFE;
  localparam int unsigned CW         = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned NSLOT      = 1 << CW;
  localparam logic [CW-1:0] LAST     = CW'(NCH - 1);

  // Reject geometries where the operand cannot be split into whole chunks
  if ((CHUNK == 0) || (WIDTH == 0) || ((WIDTH % CHUNK_SAFE) != 0)) begin : g_bad_geometry
    $error("segmented_cla_adder: WIDTH must be a nonzero multiple of CHUNK >= 1");
  end

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;
  logic             r_zero;

  logic [CHUNK-1:0] w_a_slot [NSLOT];
  logic [CHUNK-1:0] w_b_slot [NSLOT];
  logic [CHUNK-1:0] w_ca;
  logic [CHUNK-1:0] w_cb;
  logic [CHUNK-1:0] w_g;
  logic [CHUNK-1:0] w_p;
  logic [CHUNK:0]   w_c;
  logic [CHUNK-1:0] w_s;
  logic [WIDTH-1:0] w_sum_next;

  // Split latched operands into chunk slots; padding slots are never selected
  for (genvar k = 0; k < NSLOT; k++) begin : g_slot
    if (k < NCH) begin : g_real
      assign w_a_slot[k] = r_a[k*CHUNK_SAFE +: CHUNK_SAFE];
      assign w_b_slot[k] = r_b[k*CHUNK_SAFE +: CHUNK_SAFE];
    end else begin : g_pad
      assign w_a_slot[k] = '0;
      assign w_b_slot[k] = '0;
    end
  end

  assign w_ca = w_a_slot[r_cnt];
  assign w_cb = w_b_slot[r_cnt];
  assign w_g  = w_ca & w_cb;
  assign w_p  = w_ca | w_cb;

  // Flattened lookahead: every carry is a sum of generate terms gated by propagate runs
  always_comb begin
    logic run_p;
    w_c    = '0;
    run_p  = 1'b0;
    w_c[0] = r_carry;
    for (int i = 0; i < int'(CHUNK); i++) begin
      w_c[i+1] = w_g[i];
      run_p    = w_p[i];
      for (int j = i - 1; j >= 0; j--) begin
        w_c[i+1] = w_c[i+1] | (w_g[j] & run_p);
        run_p    = run_p & w_p[j];
      end
      w_c[i+1] = w_c[i+1] | (run_p & r_carry);
    end
  end

  assign w_s = w_ca ^ w_cb ^ w_c[CHUNK-1:0];

  // Merge the freshly computed chunk into the running sum
  for (genvar k = 0; k < NCH; k++) begin : g_merge
    assign w_sum_next[k*CHUNK_SAFE +: CHUNK_SAFE] =
      (r_cnt == CW'(k)) ? w_s : r_sum[k*CHUNK_SAFE +: CHUNK_SAFE];
  end

  // Control FSM with operand, carry, counter and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
      r_zero  <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (in_valid) begin
            r_a     <= a;
            r_b     <= sub ? ~b : b;
            r_carry <= sub ? ~cin : cin;
            r_cnt   <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          r_sum   <= w_sum_next;
          r_carry <= w_c[CHUNK];
          if (r_cnt == LAST) begin
            r_cout  <= w_c[CHUNK];
            r_ovf   <= w_c[CHUNK] ^ w_c[CHUNK-1];
            r_zero  <= (w_sum_next == '0);
            r_cnt   <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (out_ready) begin
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule
